// File: rtl/uart_tx_framer.sv
// rtl/uart_tx_framer.sv - UART transmit framer: start bit, LSB-first data, optional parity, stop bit
// One bit per CLK cycle; every output comes straight from a flop.

module uart_tx_framer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                  state;
  logic [CW-1:0]           bit_cnt;
  logic [CW-1:0]           nxt_cnt;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    par_en_q;
  logic                    par_typ_q;

  assign nxt_cnt = bit_cnt + CW'(1);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      TX_OUT    <= 1'b1;
      Busy      <= 1'b0;
      bit_cnt   <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Data_Valid) begin
            data_q    <= P_DATA;
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
            state     <= START;
            TX_OUT    <= 1'b0;
            Busy      <= 1'b1;
          end else begin
            TX_OUT    <= 1'b1;
            Busy      <= 1'b0;
          end
        end
        START: begin
          state   <= DATA;
          bit_cnt <= '0;
          TX_OUT  <= data_q[0];
          Busy    <= 1'b1;
        end
        DATA: begin
          Busy <= 1'b1;
          if (bit_cnt == LAST_BIT) begin
            bit_cnt <= '0;
            if (par_en_q) begin
              state  <= PARITY;
              TX_OUT <= (^data_q) ^ par_typ_q;
            end else begin
              state  <= STOP;
              TX_OUT <= 1'b1;
            end
          end else begin
            bit_cnt <= nxt_cnt;
            TX_OUT  <= data_q[nxt_cnt];
          end
        end
        PARITY: begin
          state  <= STOP;
          TX_OUT <= 1'b1;
          Busy   <= 1'b1;
        end
        STOP: begin
          state  <= IDLE;
          TX_OUT <= 1'b1;
          Busy   <= 1'b0;
        end
        // Unencoded codes fall back to a quiet line.
        default: begin
          state   <= IDLE;
          TX_OUT  <= 1'b1;
          Busy    <= 1'b0;
          bit_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_framer.md
UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the payload bits per frame.
REQ-002 CLK  input  1  bit-rate clock; one UART bit per CLK cycle; the only clock.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 P_DATA  input  DATA_WIDTH  parallel payload, sampled only on acceptance.
REQ-005 Data_Valid  input  1  request to send P_DATA; honoured only when Busy=0.
REQ-006 PAR_EN  input  1  1 = append parity bit; sampled on acceptance.
REQ-007 PAR_TYP  input  1  0 = even parity, 1 = odd parity; sampled on acceptance.
REQ-008 TX_OUT  output  1  serial line, registered, idle-high.
REQ-009 Busy  output  1  registered, high while a frame is on the line.

Function
REQ-010 The block SHALL use FSM states IDLE, START, DATA, PARITY and STOP, with all outputs driven from registers.
REQ-011 Acceptance SHALL occur on a rising CLK edge where state=IDLE and Data_Valid=1; P_DATA, PAR_EN and PAR_TYP SHALL be latched on that edge.
REQ-012 After acceptance the FSM SHALL enter START: TX_OUT=0 and Busy=1 for exactly one cycle.
REQ-013 DATA SHALL last DATA_WIDTH cycles, driving latched bits LSB first with one bit per cycle; a bit counter of width ceil(log2(DATA_WIDTH)) SHALL index the bits and wrap to 0 on exit.
REQ-014 After the last data bit the FSM SHALL go to PARITY if the latched PAR_EN=1, otherwise directly to STOP.
REQ-015 PARITY SHALL drive XOR of the latched data for even parity, or its inverse for odd parity, for one cycle.
REQ-016 STOP SHALL drive TX_OUT=1 with Busy=1 for one cycle, then the FSM SHALL enter IDLE.
REQ-017 In IDLE, TX_OUT SHALL be 1 and Busy SHALL be 0.
REQ-018 Frame length SHALL be DATA_WIDTH+2 cycles without parity and DATA_WIDTH+3 cycles with parity, and Busy SHALL be high for exactly that many cycles.
REQ-019 Data_Valid while Busy=1 SHALL be ignored, with no queuing and no corruption of the latched data.
REQ-020 Changes on P_DATA, PAR_EN or PAR_TYP after acceptance SHALL NOT affect the frame in flight.
REQ-021 Back-to-back: Data_Valid held high continuously SHALL yield frames separated by exactly one IDLE cycle (TX_OUT=1, Busy=0), during which the next frame is accepted.
REQ-022 The block SHALL NOT produce an unknown, X or illegal state; any unencoded state SHALL return to IDLE on the next edge.

Reset
REQ-023 On a CLK edge with RST=1 the block SHALL force: state=IDLE, TX_OUT=1, Busy=0, bit counter=0, latched data=0.
REQ-024 RST SHALL take priority over Data_Valid on the same edge, so no acceptance occurs.
REQ-025 RST asserted mid-frame SHALL abort the frame, with the line high from the next cycle and no stop bit emitted.
REQ-026 After RST deasserts, the first edge with Data_Valid=1 SHALL be accepted normally.

Verification
REQ-027 P_DATA=0xA5, PAR_EN=0, single Data_Valid pulse -> TX_OUT=0,1,0,1,0,0,1,0,1,1 over 10 cycles; Busy high exactly 10 cycles, then TX_OUT=1 and Busy=0.
REQ-028 P_DATA=0xA5, PAR_EN=1, PAR_TYP=0 -> parity bit 0, 11-cycle frame; repeat with PAR_TYP=1 -> parity bit 1.
REQ-029 P_DATA=0x00, PAR_EN=1, PAR_TYP=1 -> eight 0 data bits, parity 1, stop 1; change P_DATA to 0xFF during DATA -> frame unchanged.
REQ-030 Data_Valid pulsed in cycles 3 and 7 of a frame -> ignored; exactly one frame is sent and Busy falls after the stop bit.
REQ-031 Data_Valid held high with 0x55 then 0x0F, PAR_EN=0 -> two 10-cycle frames separated by exactly one idle-high cycle with Busy=0.
REQ-032 RST=1 during the 4th data bit -> next cycle TX_OUT=1 and Busy=0; a following Data_Valid produces a complete, correct frame.
